sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Purpose     : two-port arbiter in front of a single-access SRAM controller.
// Latency     : reqN_ready one cycle after mem_ready; TIMEOUT WAIT cycles max.
// Backpressure: reqN_stall holds a requester until its ready pulse.
//
// Ports
//   clk, rst        : clock; synchronous active-low reset.
//   req0_*          : port 0 (MEM stage): wen/ren/addr/wdata in; rdata/ready/stall out.
//   req1_*          : port 1 (loader), same shape as port 0.
//   req_err         : pulses with the ready pulse of an access that timed out.
//   mem_w_en/r_en   : one-hot enable towards the SRAM controller while waiting.
//   mem_addr/wdata  : latched request, zero outside WAIT.
//   mem_rdata/ready : controller read data and its one-cycle completion pulse.
module sram_arbiter #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_wen,
  input  logic        req0_ren,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic [31:0] req0_rdata,
  output logic        req0_ready,
  output logic        req0_stall,

  input  logic        req1_wen,
  input  logic        req1_ren,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic [31:0] req1_rdata,
  output logic        req1_ready,
  output logic        req1_stall,

  output logic        req_err,

  output logic        mem_w_en,
  output logic        mem_r_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Request selected by the arbiter in IDLE.
  typedef struct packed {
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  // Counter value in the last permitted WAIT cycle (counter starts at 0).
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_port;
  logic        r_wr;
  logic        r_last_grant;
  logic [7:0]  r_cnt;
  logic        r_mem_w_en;
  logic        r_mem_r_en;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic        r_ready0;
  logic        r_ready1;
  logic        r_err;

  logic        w_act0;
  logic        w_act1;
  logic        w_gnt_vld;
  logic        w_last_cycle;
  logic        w_wait_end;
  logic        w_timeout;
  grant_t      w_grant;

  assign w_act0    = req0_wen | req0_ren;
  assign w_act1    = req1_wen | req1_ren;
  assign w_gnt_vld = w_act0 | w_act1;

  // On conflict the port that was not served last wins, so the two ports
  // alternate under continuous load.
  always_comb begin
    w_grant = '0;
    if (w_act0 && w_act1) begin
      w_grant.port = ~r_last_grant;
    end else begin
      w_grant.port = w_act1;
    end
    if (w_grant.port) begin
      w_grant.wr    = req1_wen;
      w_grant.addr  = req1_addr;
      w_grant.wdata = req1_wdata;
    end else begin
      w_grant.wr    = req0_wen;
      w_grant.addr  = req0_addr;
      w_grant.wdata = req0_wdata;
    end
  end

  // mem_ready wins over the timeout in the last permitted WAIT cycle.
  assign w_last_cycle = (r_cnt == CNT_LAST);
  assign w_wait_end   = mem_ready | w_last_cycle;
  assign w_timeout    = ~mem_ready & w_last_cycle;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_port       <= 1'b0;
      r_wr         <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= 8'd0;
      r_mem_w_en   <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_rdata0     <= 32'd0;
      r_rdata1     <= 32'd0;
      r_ready0     <= 1'b0;
      r_ready1     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      r_ready0 <= 1'b0;
      r_ready1 <= 1'b0;
      r_err    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_port       <= w_grant.port;
            r_wr         <= w_grant.wr;
            r_last_grant <= w_grant.port;
            r_cnt        <= 8'd0;
            r_mem_w_en   <= w_grant.wr;
            r_mem_r_en   <= ~w_grant.wr;
            r_mem_addr   <= w_grant.addr;
            r_mem_wdata  <= w_grant.wdata;
            r_state      <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (w_wait_end) begin
            r_mem_w_en  <= 1'b0;
            r_mem_r_en  <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_cnt       <= 8'd0;
            r_ready0    <= ~r_port;
            r_ready1    <= r_port;
            r_err       <= w_timeout;
            // A timed-out read leaves the port's read data untouched.
            if (mem_ready && !r_wr) begin
              if (r_port) begin
                r_rdata1 <= mem_rdata;
              end else begin
                r_rdata0 <= mem_rdata;
              end
            end
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_w_en   = r_mem_w_en;
  assign mem_r_en   = r_mem_r_en;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign req0_rdata = r_rdata0;
  assign req1_rdata = r_rdata1;
  assign req0_ready = r_ready0;
  assign req1_ready = r_ready1;
  assign req_err    = r_err;

  // Stall is the only combinational output: it must drop in the ready cycle.
  assign req0_stall = w_act0 & ~r_ready0;
  assign req1_stall = w_act1 & ~r_ready1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Purpose     : directed bench for sram_arbiter with a transaction-level model.
// Latency     : model predicts completion at grant + min(latency, TIMEOUT) + 1.
// Backpressure: requests are held by the stimulus until the ready pulse.
module tb_sram_arbiter;

  localparam int TIMEOUT = 32;

  logic        clk;
  logic        rst;
  logic        req0_wen, req0_ren, req1_wen, req1_ren;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [31:0] req0_rdata, req1_rdata;
  logic        req0_ready, req0_stall, req1_ready, req1_stall;
  logic        req_err;
  logic        mem_w_en, mem_r_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  sram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_wen(req0_wen), .req0_ren(req0_ren), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_ready(req0_ready),
    .req0_stall(req0_stall),
    .req1_wen(req1_wen), .req1_ren(req1_ren), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_ready(req1_ready),
    .req1_stall(req1_stall),
    .req_err(req_err),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SRAM controller responder ----------------
  // lat = N: mem_ready in the Nth consecutive enable cycle; lat = 0: never.
  int          lat      = 0;
  int          en_cnt   = 0;
  logic        resp_rdy = 1'b0;
  logic        spur     = 1'b0;
  logic [31:0] rd_base  = 32'd0;

  always @(posedge clk) begin
    #1;
    if ((mem_r_en | mem_w_en) === 1'b1) en_cnt++;
    else en_cnt = 0;
    resp_rdy = (lat != 0) && (en_cnt == lat);
  end

  assign mem_ready = resp_rdy | spur;
  assign mem_rdata = resp_rdy ? rd_base : 32'hBAD0_0000;

  // ---------------- transaction-level model ----------------
  logic        m_rst_prev = 1'b0;
  logic        m_live     = 1'b0;
  logic        m_busy     = 1'b0;
  logic        m_last     = 1'b1;
  logic        m_port, m_wr, m_err;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata [2];
  int          m_g, m_w, m_d;
  int          m_idle_from = 0;

  always @(negedge clk) begin
    logic e_en, e_done, a0, a1;
    if (m_rst_prev) begin
      m_live      = 1'b1;
      m_busy      = 1'b0;
      m_last      = 1'b1;
      m_rdata[0]  = 32'd0;
      m_rdata[1]  = 32'd0;
      m_idle_from = cyc;
    end
    if (m_live) begin
      e_en   = m_busy && (cyc > m_g) && (cyc <= m_g + m_w);
      e_done = m_busy && (cyc == m_d);
      if (e_done && !m_wr && !m_err) m_rdata[m_port] = rd_base;
      chk("mem_w_en",   mem_w_en,   e_en & m_wr);
      chk("mem_r_en",   mem_r_en,   e_en & ~m_wr);
      chk("mem_addr",   mem_addr,   e_en ? m_addr  : 32'd0);
      chk("mem_wdata",  mem_wdata,  e_en ? m_wdata : 32'd0);
      chk("req0_ready", req0_ready, e_done & ~m_port);
      chk("req1_ready", req1_ready, e_done & m_port);
      chk("req_err",    req_err,    e_done & m_err);
      chk("req0_rdata", req0_rdata, m_rdata[0]);
      chk("req1_rdata", req1_rdata, m_rdata[1]);
      chk("req0_stall", req0_stall, (req0_wen | req0_ren) & ~(e_done & ~m_port));
      chk("req1_stall", req1_stall, (req1_wen | req1_ren) & ~(e_done & m_port));
    end
    m_rst_prev = ~rst;
    if (rst && m_live && cyc >= m_idle_from) begin
      a0 = req0_wen | req0_ren;
      a1 = req1_wen | req1_ren;
      if (a0 || a1) begin
        m_port  = (a0 && a1) ? ~m_last : a1;
        m_wr    = m_port ? req1_wen   : req0_wen;
        m_addr  = m_port ? req1_addr  : req0_addr;
        m_wdata = m_port ? req1_wdata : req0_wdata;
        m_err   = !(lat >= 1 && lat <= TIMEOUT);
        m_w     = m_err ? TIMEOUT : lat;
        m_g     = cyc;
        m_d     = cyc + m_w + 1;
        m_idle_from = m_d + 1;
        m_busy  = 1'b1;
        m_last  = m_port;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input logic port, input int bound, input string name);
    logic got = 1'b0;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge clk);
      if ((port ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
    end
    if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  int q[$];

  initial begin
    rst = 1'b0;
    req0_wen = 0; req0_ren = 0; req0_addr = 0; req0_wdata = 0;
    req1_wen = 0; req1_ren = 0; req1_addr = 0; req1_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_r_en", mem_r_en, 1'b0);
    chk("rst_rdata0", req0_rdata, 32'd0);
    step();

    // Port 0 read of 0x100, ready in the 6th enable cycle.
    lat = 6; rd_base = 32'hDEAD_BEEF;
    req0_ren = 1; req0_addr = 32'h100;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      chk("r30_stall", req0_stall, k < 7);
      chk("r30_ready", req0_ready, k == 7);
      chk("r30_ren", mem_r_en, k >= 1 && k <= 6);
      if (k >= 1 && k <= 6) chk("r30_addr", mem_addr, 32'h100);
      if (k == 7) chk("r30_rdata", req0_rdata, 32'hDEAD_BEEF);
    end
    step(); req0_ren = 0;
    repeat (2) step();

    // Port 1 with wen and ren both set: a write.
    lat = 3;
    req1_wen = 1; req1_ren = 1; req1_addr = 32'h200; req1_wdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    chk("r32_wen", mem_w_en, 1'b1);
    chk("r32_ren", mem_r_en, 1'b0);
    chk("r32_wdata", mem_wdata, 32'h1234_5678);
    wait_ready(1'b1, 10, "r32");
    chk("r32_rdata1", req1_rdata, 32'd0);
    step(); req1_wen = 0; req1_ren = 0;
    repeat (2) step();

    // Both ports reading continuously: grants alternate starting with port 0.
    lat = 4; rd_base = 32'hA5A5_0001;
    req0_ren = 1; req0_addr = 32'h10; req1_ren = 1; req1_addr = 32'h20;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req0_ready === 1'b1) q.push_back(0);
      if (req1_ready === 1'b1) q.push_back(1);
    end
    step(); req0_ren = 0; req1_ren = 0;
    chk("r31_count", q.size() >= 4, 1'b1);
    if (q.size() >= 4)
      for (int i = 0; i < 4; i++) chk("r31_order", q[i], i % 2);
    repeat (10) step();

    // Port 0 held across completion: one enable-free IDLE cycle after DONE.
    lat = 2; rd_base = 32'h0BAD_F00D;
    req0_ren = 1; req0_addr = 32'h44;
    wait_ready(1'b0, 10, "r35a");
    chk("r35_done_ren", mem_r_en, 1'b0);
    @(negedge clk);
    chk("r35_idle_ren", mem_r_en, 1'b0);
    @(negedge clk);
    chk("r35_new_ren", mem_r_en, 1'b1);
    wait_ready(1'b0, 10, "r35b");
    step(); req0_ren = 0;
    repeat (2) step();

    // Ready in the last permitted WAIT cycle is a normal completion.
    lat = TIMEOUT;
    req0_wen = 1; req0_addr = 32'h400; req0_wdata = 32'hCAFE_F00D;
    wait_ready(1'b0, TIMEOUT + 5, "edge");
    chk("edge_err", req_err, 1'b0);
    step(); req0_wen = 0;
    repeat (2) step();

    // Controller never answers: timeout after TIMEOUT WAIT cycles.
    lat = 0;
    req1_ren = 1; req1_addr = 32'h500;
    for (int k = 0; k <= TIMEOUT + 2; k++) begin
      @(negedge clk);
      if (k == TIMEOUT) chk("r33_ren_last", mem_r_en, 1'b1);
      if (k == TIMEOUT + 1) begin
        chk("r33_ren_drop", mem_r_en, 1'b0);
        chk("r33_err", req_err, 1'b1);
        chk("r33_ready", req1_ready, 1'b1);
        step(); req1_ren = 0;
      end
      if (k == TIMEOUT + 2) chk("r33_err_pulse", req_err, 1'b0);
    end
    // A stray mem_ready while idle is ignored.
    step(); spur = 1'b1;
    step(); spur = 1'b0;
    repeat (3) step();

    // Reset in the middle of a port 1 WAIT, then a conflict goes to port 0.
    lat = 0;
    req1_ren = 1; req1_addr = 32'h600;
    repeat (5) step();
    rst = 1'b0;
    @(negedge clk);
    chk("r34_pre_ren", mem_r_en, 1'b1);
    step();
    rst = 1'b1; lat = 3; rd_base = 32'h3C3C_3C3C;
    req0_ren = 1; req0_addr = 32'h300;
    @(negedge clk);
    chk("r34_ren_off", mem_r_en, 1'b0);
    chk("r34_rdata1_clr", req1_rdata, 32'd0);
    begin
      logic got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if ((req0_ready | req1_ready) === 1'b1) begin
          got = 1'b1;
          chk("r34_first_port0", req0_ready, 1'b1);
          chk("r34_rdata0", req0_rdata, 32'h3C3C_3C3C);
        end
      end
      if (!got) chk("r34_timeout", 32'd0, 32'd1);
    end
    step(); req0_ren = 0; req1_ren = 0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
